eth_gmii_tx_framer: RTL
=======================

ETH_GMII_TX_FRAMER -- requirements
Module: eth_gmii_tx_framer

Interface
REQ-001 Parameter PRE_LEN, default 7, number of 0x55 preamble bytes before SFD.
REQ-002 Parameter IFG_LEN, default 12, idle cycles enforced after every frame end or abort.
REQ-003 Parameter FCS_EN, default 1, 1 = append 4-byte FCS after payload; 0 = no FCS.
REQ-004 clk  input  1  TX byte clock (gmii_tx_clk domain); single clock, all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 s_valid  input  1  payload byte valid.
REQ-007 s_data  input  8  payload byte (destination MAC first).
REQ-008 s_last  input  1  marks final payload byte of frame.
REQ-009 s_ready  output  1  framer accepts s_data this cycle when s_valid && s_ready.
REQ-010 gmii_tx_en  output  1  GMII transmit enable.
REQ-011 gmii_txd  output  8  GMII transmit data.
REQ-012 gmii_tx_er  output  1  GMII transmit error (abort marker).
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 underrun  output  1  single-cycle pulse when a frame is aborted for missing payload.

Function
REQ-015 States IDLE, PRE, SFD, DATA, FCS, IFG; gmii_tx_en, gmii_txd, gmii_tx_er all registered.
REQ-016 IDLE: s_ready=0; s_valid=1 sampled -> PRE next cycle; first 0x55 appears on gmii_txd with gmii_tx_en=1 in the cycle after the start-decision edge.
REQ-017 PRE: exactly PRE_LEN consecutive bytes 0x55 with tx_en=1, then SFD.
REQ-018 SFD: exactly one byte 0xD5 with tx_en=1, then DATA.
REQ-019 DATA: s_ready=1 (combinational from state); an accepted byte appears on gmii_txd one cycle after acceptance; no byte is dropped or duplicated.
REQ-020 DATA with s_valid=0: abort -- drive one cycle gmii_tx_en=1, gmii_tx_er=1, gmii_txd=0x00, pulse underrun, go to IFG; no FCS sent.
REQ-021 DATA accepting byte with s_last=1: go to FCS if FCS_EN=1, else IFG; a 1-byte payload is legal.
REQ-022 FCS: CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) over payload bytes only, transmitted as bitwise complement, least significant byte first, 4 cycles, s_ready=0.
REQ-023 CRC register reinitialises to 0xFFFFFFFF on every IDLE->PRE transition.
REQ-024 IFG: gmii_tx_en=0, gmii_txd=0x00, gmii_tx_er=0 for exactly IFG_LEN cycles, s_ready=0, s_valid ignored; then IDLE.
REQ-025 Back-to-back: s_valid held high across IFG -> next preamble starts IFG_LEN+1 cycles after last FCS byte (IFG_LEN idle + IDLE decision cycle).
REQ-026 No minimum-length padding; payload length is upstream's responsibility.
REQ-027 gmii_tx_er=0 in all states except the abort cycle.

Reset
REQ-028 rst_n low: state=IDLE, gmii_tx_en=0, gmii_txd=0x00, gmii_tx_er=0, underrun=0, CRC=0xFFFFFFFF, counters=0, immediately (asynchronous), including mid-frame.
REQ-029 After rst_n release, no frame starts until s_valid is sampled high in IDLE; no partial frame resumes.

Structure
REQ-030 Shared package eth_pkg holds state encoding, PREAMBLE_BYTE 0x55, SFD_BYTE 0xD5, CRC32_POLY, CRC32_INIT.
REQ-031 Byte-wise CRC update is one sub-module, eth_crc32_d8 (combinational next-CRC from crc_in and data byte), reusable by the RX checker.
REQ-032 Preamble, FCS and IFG share one down-counter sized for max(PRE_LEN, IFG_LEN).

Verification
REQ-033 Payload "123456789" (0x31..0x39, s_last on 0x39), FCS_EN=1 -> 7x 0x55, 0xD5, 0x31..0x39, then 0x26,0x39,0xF4,0xCB, tx_en high 21 cycles, then 12 idle cycles.
REQ-034 Single payload byte 0xAA with s_last -> 0x55x7, 0xD5, 0xAA, 4 FCS bytes, tx_en high 13 cycles.
REQ-035 s_valid dropped after 3rd of 10 bytes -> 3 bytes sent, then one cycle tx_en=1/tx_er=1/txd=0x00, underrun pulse, 12 idle cycles, busy low afterwards.
REQ-036 Two 60-byte frames with s_valid continuously high -> exactly 12 tx_en=0 cycles + 1 IDLE cycle between last FCS byte and next 0x55.
REQ-037 rst_n asserted during DATA byte 5 -> tx_en, tx_er drop same cycle (async); after release with s_valid=0 line stays idle; new frame carries fresh correct FCS.
REQ-038 FCS_EN=0, 4-byte payload 0x01..0x04 -> tx_en high 12 cycles ending with 0x04, no FCS bytes.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet constants: framer state encoding, preamble/SFD bytes and CRC-32 parameters.
package eth_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_SFD  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_FCS  = 3'd4;
    localparam logic [2:0] ST_IFG  = 3'd5;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            r[i] = v[31 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Byte-wise reflected CRC-32 next-state logic (LSB of the data byte first).
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

    always_comb begin
        crc_out = crc_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (crc_out[0] ^ data[i]) begin
                crc_out = (crc_out >> 1) ^ POLY_REFL;
            end else begin
                crc_out = crc_out >> 1;
            end
        end
    end

endmodule

// File: rtl/eth_gmii_tx_framer.sv
// GMII transmit framer: preamble, SFD, streamed payload, optional FCS and inter-frame gap.
module eth_gmii_tx_framer
    import eth_pkg::*;
#(
    parameter int unsigned PRE_LEN = 7,
    parameter int unsigned IFG_LEN = 12,
    parameter bit          FCS_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_er,
    output logic       busy,
    output logic       underrun
);

    localparam int unsigned CNT_MAX = (PRE_LEN > IFG_LEN) ? ((PRE_LEN > 3) ? PRE_LEN : 3)
                                                          : ((IFG_LEN > 3) ? IFG_LEN : 3);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      crc;
    logic [31:0]      crc_next;
    logic [1:0]       fcs_sel;
    logic [7:0]       fcs_byte;

    // State names the byte being registered at the coming edge, so the line lags state by one cycle.
    assign s_ready  = (state == ST_DATA);
    assign busy     = (state != ST_IDLE);
    assign fcs_sel  = ~cnt[1:0];
    assign fcs_byte = ~crc[{fcs_sel, 3'b000} +: 8];

    eth_crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (s_data),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            crc        <= CRC32_INIT;
            gmii_tx_en <= 1'b0;
            gmii_txd   <= '0;
            gmii_tx_er <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            gmii_tx_en <= 1'b0;
            gmii_txd   <= '0;
            gmii_tx_er <= 1'b0;
            underrun   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s_valid) begin
                        gmii_tx_en <= 1'b1;
                        gmii_txd   <= PREAMBLE_BYTE;
                        crc        <= CRC32_INIT;
                        cnt        <= CNT_W'(PRE_LEN - 1);
                        state      <= (PRE_LEN > 1) ? ST_PRE : ST_SFD;
                    end
                end
                ST_PRE: begin
                    gmii_tx_en <= 1'b1;
                    gmii_txd   <= PREAMBLE_BYTE;
                    cnt        <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_SFD;
                    end
                end
                ST_SFD: begin
                    gmii_tx_en <= 1'b1;
                    gmii_txd   <= SFD_BYTE;
                    state      <= ST_DATA;
                end
                ST_DATA: begin
                    gmii_tx_en <= 1'b1;
                    if (s_valid) begin
                        gmii_txd <= s_data;
                        crc      <= crc_next;
                        if (s_last) begin
                            if (FCS_EN) begin
                                state <= ST_FCS;
                                cnt   <= CNT_W'(3);
                            end else begin
                                state <= ST_IFG;
                                cnt   <= CNT_W'(IFG_LEN);
                            end
                        end
                    end else begin
                        gmii_tx_er <= 1'b1;
                        underrun   <= 1'b1;
                        state      <= ST_IFG;
                        cnt        <= CNT_W'(IFG_LEN);
                    end
                end
                ST_FCS: begin
                    gmii_tx_en <= 1'b1;
                    gmii_txd   <= fcs_byte;
                    if (cnt == '0) begin
                        state <= ST_IFG;
                        cnt   <= CNT_W'(IFG_LEN);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                // First IFG cycle still shows the final byte, hence IFG_LEN+1 cycles in this state.
                ST_IFG: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
